// File: rtl/line_rasterizer_pkg.sv
// Shared widths, screen extent, FSM state encoding and coordinate types for the line rasterizer.
// LINE_RASTERIZER_CLEAR_EN adds the power-up screen-clear state.
package line_pkg;

  localparam int DEF_X_W   = 9;
  localparam int DEF_Y_W   = 8;
  localparam int DEF_COL_W = 3;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;

  typedef logic [DEF_X_W-1:0]   coord_x_t;
  typedef logic [DEF_Y_W-1:0]   coord_y_t;
  typedef logic [DEF_COL_W-1:0] colour_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRAW,
    ST_DONE
`ifdef LINE_RASTERIZER_CLEAR_EN
    , ST_CLEAR
`endif
  } state_t;

`ifdef LINE_RASTERIZER_CLEAR_EN
  localparam state_t ST_RESET = ST_CLEAR;
`else
  localparam state_t ST_RESET = ST_IDLE;
`endif

endpackage

// File: rtl/line_rasterizer_if.sv
// UI-control / VGA-adapter signal bundle of the line rasterizer.
interface line_rasterizer_if #(
  parameter int X_W   = line_pkg::DEF_X_W,
  parameter int Y_W   = line_pkg::DEF_Y_W,
  parameter int COL_W = line_pkg::DEF_COL_W
);
  logic             start;
  logic [X_W-1:0]   x0;
  logic [X_W-1:0]   x1;
  logic [Y_W-1:0]   y0;
  logic [Y_W-1:0]   y1;
  logic [COL_W-1:0] colour_in;
  logic             plot;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             done;

  modport master (output start, x0, x1, y0, y1, colour_in,
                  input  plot, x, y, colour, done);
  modport slave  (input  start, x0, x1, y0, y1, colour_in,
                  output plot, x, y, colour, done);
endinterface

// File: rtl/line_rasterizer_setup.sv
// Combinational Bresenham setup: steep test, axis/endpoint swap, spans and initial error.
module line_setup
  import line_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic                  i_x0_unused_guard,
  input  logic [X_W-1:0]        i_x0,
  input  logic [X_W-1:0]        i_x1,
  input  logic [Y_W-1:0]        i_y0,
  input  logic [Y_W-1:0]        i_y1,
  output logic                  o_steep,
  output logic                  o_step_neg,
  output logic [X_W-1:0]        o_a_start,
  output logic [X_W-1:0]        o_a_end,
  output logic [X_W-1:0]        o_b_start,
  output logic signed [X_W:0]   o_dx,
  output logic signed [X_W:0]   o_dy,
  output logic signed [X_W+1:0] o_err
);
  logic [X_W-1:0]      w_y0, w_y1, w_pa0, w_pa1, w_pb0, w_pb1, w_b_end;
  logic signed [X_W:0] w_sx, w_sy, w_ax, w_ay, w_db;
  logic                w_swap;

  always_comb begin
    w_y0 = X_W'(i_y0);
    w_y1 = X_W'(i_y1);
    w_sx = $signed({1'b0, i_x1}) - $signed({1'b0, i_x0});
    w_sy = $signed({1'b0, w_y1}) - $signed({1'b0, w_y0});
    w_ax = w_sx[X_W] ? -w_sx : w_sx;
    w_ay = w_sy[X_W] ? -w_sy : w_sy;
    o_steep = (w_ay > w_ax) && !i_x0_unused_guard;
    // a = major axis, b = minor axis
    w_pa0 = o_steep ? w_y0 : i_x0;
    w_pa1 = o_steep ? w_y1 : i_x1;
    w_pb0 = o_steep ? i_x0 : w_y0;
    w_pb1 = o_steep ? i_x1 : w_y1;
    w_swap    = w_pa0 > w_pa1;
    o_a_start = w_swap ? w_pa1 : w_pa0;
    o_a_end   = w_swap ? w_pa0 : w_pa1;
    o_b_start = w_swap ? w_pb1 : w_pb0;
    w_b_end   = w_swap ? w_pb0 : w_pb1;
    o_dx = $signed({1'b0, o_a_end}) - $signed({1'b0, o_a_start});
    w_db = $signed({1'b0, w_b_end}) - $signed({1'b0, o_b_start});
    o_dy = w_db[X_W] ? -w_db : w_db;
    o_step_neg = w_db[X_W];
    o_err = -$signed({2'b00, o_dx[X_W:1]});
  end
endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches a line request, emits one pixel strobe per cycle, four-phase done.
// LINE_RASTERIZER_CLEAR_EN: reset first sweeps colour 0 over the whole screen.
module line_rasterizer
  import line_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COL_W    = DEF_COL_W,
  parameter int SCREEN_W = line_pkg::SCREEN_W,
  parameter int SCREEN_H = line_pkg::SCREEN_H
) (
  input logic              clk,
  input logic              reset,
  line_rasterizer_if.slave bus
);
  if (Y_W > X_W) begin : g_bad_width
    $error("line_rasterizer: Y_W must not exceed X_W");
  end
  if (SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_bad_screen
    $error("line_rasterizer: screen extent does not fit coordinate widths");
  end

  state_t                r_state, w_next;
  logic [X_W-1:0]        r_x0, r_x1, r_a, r_b, r_a_end;
  logic [Y_W-1:0]        r_y0, r_y1;
  logic [COL_W-1:0]      r_col;
  logic                  r_steep, r_step_neg;
  logic signed [X_W:0]   r_dx, r_dy;
  logic signed [X_W+1:0] r_err, w_err_add, w_err_sub;
  logic                  w_minor_step, w_last;

  logic                  w_steep, w_step_neg;
  logic [X_W-1:0]        w_a_start, w_a_end, w_b_start;
  logic signed [X_W:0]   w_dx, w_dy;
  logic signed [X_W+1:0] w_err;

  line_setup #(.X_W(X_W), .Y_W(Y_W)) u_setup (
    .i_x0_unused_guard(1'b0),
    .i_x0(r_x0), .i_x1(r_x1), .i_y0(r_y0), .i_y1(r_y1),
    .o_steep(w_steep), .o_step_neg(w_step_neg),
    .o_a_start(w_a_start), .o_a_end(w_a_end), .o_b_start(w_b_start),
    .o_dx(w_dx), .o_dy(w_dy), .o_err(w_err)
  );

  assign w_err_add    = r_err + {r_dy[X_W], r_dy};
  assign w_err_sub    = w_err_add - {r_dx[X_W], r_dx};
  assign w_minor_step = !w_err_add[X_W+1] && (w_err_add != '0);
  assign w_last       = (r_a == r_a_end);

`ifdef LINE_RASTERIZER_CLEAR_EN
  logic [X_W-1:0] r_cx;
  logic [Y_W-1:0] r_cy;
  logic           w_clr_last;
  assign w_clr_last = (r_cx == X_W'(SCREEN_W - 1)) && (r_cy == Y_W'(SCREEN_H - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_cx == X_W'(SCREEN_W - 1)) begin
        r_cx <= '0;
        r_cy <= r_cy + Y_W'(1);
      end else begin
        r_cx <= r_cx + X_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    bus.plot   = 1'b0;
    bus.done   = 1'b0;
    bus.x      = '0;
    bus.y      = '0;
    bus.colour = '0;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_SETUP;
      ST_SETUP: w_next = ST_DRAW;
      ST_DRAW: begin
        bus.plot   = 1'b1;
        bus.colour = r_col;
        bus.x      = r_steep ? r_b : r_a;
        bus.y      = r_steep ? r_a[Y_W-1:0] : r_b[Y_W-1:0];
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        if (!bus.start) w_next = ST_IDLE;
      end
`ifdef LINE_RASTERIZER_CLEAR_EN
      ST_CLEAR: begin
        // strobe stays low while reset is held in this state
        bus.plot = !reset;
        bus.x    = r_cx;
        bus.y    = r_cy;
        if (w_clr_last) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0 <= '0; r_x1 <= '0; r_y0 <= '0; r_y1 <= '0; r_col <= '0;
      r_steep <= 1'b0; r_step_neg <= 1'b0;
      r_a <= '0; r_b <= '0; r_a_end <= '0;
      r_dx <= '0; r_dy <= '0; r_err <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) begin
          r_x0  <= bus.x0;
          r_x1  <= bus.x1;
          r_y0  <= bus.y0;
          r_y1  <= bus.y1;
          r_col <= bus.colour_in;
        end
        ST_SETUP: begin
          r_steep    <= w_steep;
          r_step_neg <= w_step_neg;
          r_a        <= w_a_start;
          r_a_end    <= w_a_end;
          r_b        <= w_b_start;
          r_dx       <= w_dx;
          r_dy       <= w_dy;
          r_err      <= w_err;
        end
        ST_DRAW: begin
          r_a <= r_a + X_W'(1);
          if (w_minor_step) begin
            r_err <= w_err_sub;
            r_b   <= r_step_neg ? r_b - X_W'(1) : r_b + X_W'(1);
          end else begin
            r_err <= w_err_add;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: vector table + pixel scoreboard + reset/handshake sequences.
module tb_line_rasterizer;
  import line_pkg::*;

  typedef struct {
    int x0; int y0; int x1; int y1; int col; int n;
  } vec_t;
  typedef struct {
    int x; int y; int col;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  pix_t exp_q[$];
  vec_t vecs[$];

  line_rasterizer_if bus ();
  line_rasterizer dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Closed-form pixel model: minor offset of pixel i is ceil((i*dy - dx/2) / dx), clamped at 0.
  function automatic void push_model(input vec_t v);
    bit steep;
    int a0, a1, b0, b1, t, dx, dy, h, sgn, off, a, b;
    pix_t p;
    steep = iabs(v.y1 - v.y0) > iabs(v.x1 - v.x0);
    a0 = steep ? v.y0 : v.x0;  a1 = steep ? v.y1 : v.x1;
    b0 = steep ? v.x0 : v.y0;  b1 = steep ? v.x1 : v.y1;
    if (a0 > a1) begin
      t = a0; a0 = a1; a1 = t;
      t = b0; b0 = b1; b1 = t;
    end
    dx = a1 - a0;
    dy = iabs(b1 - b0);
    h = dx / 2;
    sgn = (b1 >= b0) ? 1 : -1;
    for (int i = 0; i <= dx; i++) begin
      off = (dx == 0) ? 0 : (i * dy - h + dx - 1) / dx;
      a = a0 + i;
      b = b0 + sgn * off;
      p.x = (steep ? b : a) & 511;
      p.y = (steep ? a : b) & 255;
      p.col = v.col;
      exp_q.push_back(p);
    end
  endfunction

  task automatic drive_line(input vec_t v);
    bus.x0 = v.x0[8:0]; bus.y0 = v.y0[7:0];
    bus.x1 = v.x1[8:0]; bus.y1 = v.y1[7:0];
    bus.colour_in = v.col[2:0];
    bus.start = 1'b1;
  endtask

  task automatic run_line(input vec_t v, input int hold, input bit use_model);
    int first, last, donec, nplot;
    pix_t e;
    first = -1; last = -1; donec = -1; nplot = 0;
    @(negedge clk);
    drive_line(v);
    if (use_model) push_model(v);
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // request inputs change after latching and must be ignored
        bus.x0 = 9'($urandom); bus.y0 = 8'($urandom);
        bus.x1 = 9'($urandom); bus.y1 = 8'($urandom);
        bus.colour_in = 3'($urandom);
      end
      if (bus.plot && bus.done) chk("plot_done_overlap", 1, 0);
      if (bus.plot) begin
        if (first < 0) first = c;
        last = c;
        nplot++;
        if (exp_q.size() == 0) chk("extra_plot", nplot, v.n);
        else begin
          e = exp_q.pop_front();
          chk("pix_x", int'(bus.x), e.x);
          chk("pix_y", int'(bus.y), e.y);
          chk("pix_colour", int'(bus.colour), e.col);
        end
      end
      if (bus.done) begin
        donec = c;
        break;
      end
    end
    if (donec < 0) chk("done_timeout", donec, 0);
    chk("plot_count", nplot, v.n);
    chk("first_plot_latency", first, 2);
    chk("done_after_last_plot", donec, last + 1);
    chk("no_plot_gaps", last - first + 1, nplot);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("done_held", int'(bus.done), 1);
      chk("no_plot_in_done", int'(bus.plot), 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_released", int'(bus.done), 0);
    @(negedge clk);
    chk("idle_quiet", int'(bus.plot | bus.done), 0);
  endtask

`ifdef LINE_RASTERIZER_CLEAR_EN
  task automatic wait_clear();
    int cnt, bad_col;
    bit seen;
    cnt = 0; bad_col = 0; seen = 0;
    for (int c = 0; c < 80000; c++) begin
      @(negedge clk);
      if (bus.plot) begin
        if (cnt == 0) begin
          chk("clear_first_x", int'(bus.x), 0);
          chk("clear_first_y", int'(bus.y), 0);
        end
        if (cnt == 1) chk("clear_x_fastest", int'(bus.x), 1);
        if (bus.colour != 0) bad_col++;
        cnt++;
        seen = 1;
      end else if (seen) break;
    end
    chk("clear_count", cnt, SCREEN_W * SCREEN_H);
    chk("clear_colour0", bad_col, 0);
  endtask
`endif

  initial begin
    vec_t v;
    int np;
    bus.start = 1'b0;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0; bus.colour_in = '0;

    #2;
    chk("reset_plot", int'(bus.plot), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_x", int'(bus.x), 0);
    chk("reset_y", int'(bus.y), 0);
    chk("reset_colour", int'(bus.colour), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
`ifdef LINE_RASTERIZER_CLEAR_EN
    wait_clear();
`endif

    // x0, y0, x1, y1, colour, expected pixel count
    vecs.push_back('{10, 20, 14, 20, 5, 5});
    vecs.push_back('{5, 3, 1, 3, 2, 5});
    vecs.push_back('{7, 7, 7, 7, 4, 1});
    vecs.push_back('{0, 0, 3, 3, 1, 4});
    vecs.push_back('{0, 10, 8, 6, 3, 9});
    vecs.push_back('{20, 30, 17, 2, 6, 29});
    vecs.push_back('{319, 0, 0, 239, 7, 320});
    vecs.push_back('{511, 255, 0, 0, 1, 512});
    vecs.push_back('{100, 200, 100, 50, 2, 151});
    for (int i = 0; i < 6; i++) begin
      v.x0 = $urandom_range(319); v.y0 = $urandom_range(239);
      v.x1 = $urandom_range(319); v.y1 = $urandom_range(239);
      v.col = $urandom_range(7);
      np = iabs(v.x1 - v.x0);
      if (iabs(v.y1 - v.y0) > np) np = iabs(v.y1 - v.y0);
      v.n = np + 1;
      vecs.push_back(v);
    end
    foreach (vecs[i]) run_line(vecs[i], 0, 1'b1);

    // steep line with hand-written pixel order
    exp_q.push_back('{0, 0, 3});
    exp_q.push_back('{0, 1, 3});
    exp_q.push_back('{1, 2, 3});
    exp_q.push_back('{1, 3, 3});
    exp_q.push_back('{2, 4, 3});
    exp_q.push_back('{2, 5, 3});
    run_line('{0, 0, 2, 5, 3, 6}, 0, 1'b0);

    // start held four cycles past done
    run_line('{30, 40, 36, 43, 6, 7}, 4, 1'b1);

    // reset in the middle of a long line
    @(negedge clk);
    drive_line('{0, 0, 100, 0, 6, 101});
    np = 0;
    for (int c = 0; c < 20 && np < 3; c++) begin
      @(negedge clk);
      if (bus.plot) np++;
    end
    chk("reset_test_plots_seen", np, 3);
    #2 reset = 1'b1;
    #1;
    chk("midline_reset_plot", int'(bus.plot), 0);
    chk("midline_reset_done", int'(bus.done), 0);
    chk("midline_reset_x", int'(bus.x), 0);
    chk("midline_reset_y", int'(bus.y), 0);
    chk("midline_reset_colour", int'(bus.colour), 0);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
`ifdef LINE_RASTERIZER_CLEAR_EN
    wait_clear();
`else
    np = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.plot || bus.done) np++;
    end
    chk("aborted_line_no_resume", np, 0);
`endif
    run_line('{0, 0, 3, 3, 5, 4}, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
